// File: rtl/fpadd_operand_fifo.sv
// ---------------------------------------------------------------------------
// fpadd_operand_fifo
//   Buffered operand front end for the floating-point adder. Operand pairs
//   (A, B) arrive over a valid/ready handshake, are held in a small circular
//   FIFO and the head pair is presented to the adder input stage, which pops
//   it with its own ready. Occupancy and a high-water mark are exported for
//   software.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous reset, active low
//   flush       synchronous clear of all entries and the high-water mark
//   in_valid    upstream offers a pair
//   in_ready    FIFO can take a pair this cycle (level != DEPTH)
//   in_a/in_b   incoming operands
//   out_valid   head pair valid (level != 0)
//   out_ready   adder consumes the head pair
//   out_a/out_b head operands
//   level       number of stored pairs, 0..DEPTH
//   high_water  largest level seen since reset or flush
// ---------------------------------------------------------------------------
module fpadd_operand_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [CNT_W-1:0]  level,
    output logic [CNT_W-1:0]  high_water
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] level_q;
    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] level_next;
    logic             push;
    logic             pop;

    // Handshake qualifiers depend on the registered level only, so there is
    // no combinational path from out_ready to in_ready.
    assign in_ready  = (level_q != CNT_W'(DEPTH));
    assign out_valid = (level_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head data is gated by out_valid so the outputs read zero out of reset
    // even though the storage itself is never cleared.
    assign out_a = out_valid ? mem_a[rd_ptr] : '0;
    assign out_b = out_valid ? mem_b[rd_ptr] : '0;

    assign level      = level_q;
    assign high_water = high_q;

    always_comb begin
        level_next = level_q;
        if (push && !pop) begin
            level_next = level_q + CNT_W'(1);
        end else if (pop && !push) begin
            level_next = level_q - CNT_W'(1);
        end
    end

    // Storage has no reset; a flushed cycle must not write.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            high_q  <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            high_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level_q <= level_next;
            if (level_next > high_q) begin
                high_q <= level_next;
            end
        end
    end

endmodule

// File: tb/tb_fpadd_operand_fifo.sv
// ---------------------------------------------------------------------------
// tb_fpadd_operand_fifo
//   Directed bench for fpadd_operand_fifo. A queue holds the pairs the bench
//   expects to be stored; its size is the expected level, its head is the
//   expected out_a/out_b.
// ---------------------------------------------------------------------------
module tb_fpadd_operand_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [CNT_W-1:0]  level;
    logic [CNT_W-1:0]  high_water;

    int checks   = 0;
    int failures = 0;

    logic [63:0] sb [$];
    int          hw_model = 0;

    fpadd_operand_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .level     (level),
        .high_water(high_water)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check outputs against the scoreboard before the edge,
    // then advance the model across the edge.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic r, input logic fl);
        bit do_push;
        bit do_pop;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        out_ready = r;
        flush     = fl;
        #1;
        check("in_ready",   32'(in_ready),   32'(sb.size() != DEPTH));
        check("out_valid",  32'(out_valid),  32'(sb.size() != 0));
        check("level",      32'(level),      32'(sb.size()));
        check("high_water", 32'(high_water), 32'(hw_model));
        if (sb.size() != 0) begin
            check("out_a", out_a, sb[0][63:32]);
            check("out_b", out_b, sb[0][31:0]);
        end
        do_push = v && (sb.size() != DEPTH);
        do_pop  = r && (sb.size() != 0);
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
            hw_model = 0;
        end else begin
            if (do_pop)  void'(sb.pop_front());
            if (do_push) sb.push_back({a, b});
            if (sb.size() > hw_model) hw_model = sb.size();
        end
    endtask

    task automatic idle_check();
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0;

        // Reset held for 3 cycles, then idle.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_a", out_a, 32'h0);
        check("rst_out_b", out_b, 32'h0);
        reset = 1'b1;
        idle_check();

        // Single pair, held for 5 cycles without a pop.
        cycle(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0);
        repeat (5) begin
            idle_check();
            check("single_a", out_a, 32'h3F80_0000);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle_check();

        // Fill: 5 back-to-back pushes, the 5th must be refused.
        for (int unsigned i = 0; i < 5; i++) begin
            cycle(1'b1, 32'h1000_0000 + i, 32'h2000_0000 + i, 1'b0, 1'b0);
        end
        check("full_level", 32'(level), 32'd4);
        check("full_hw",    32'(high_water), 32'd4);
        check("full_ready", 32'(in_ready), 32'd0);
        // Pop while full with in_valid high: no pass-through push.
        cycle(1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0);
        check("no_passthru", 32'(level), 32'd3);
        for (int unsigned i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        idle_check();
        check("drain_hw", 32'(high_water), 32'd4);

        // Continuous streaming: pointers wrap several times.
        for (int unsigned i = 0; i < 10; i++) begin
            cycle(1'b1, 32'hA000_0000 + i, 32'hB000_0000 + i, 1'b1, 1'b0);
            check("stream_level", 32'(level), 32'd1);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle_check();

        // Flush with simultaneous push and pop at level 3.
        for (int unsigned i = 0; i < 3; i++) begin
            cycle(1'b1, 32'hC000_0000 + i, 32'hD000_0000 + i, 1'b0, 1'b0);
        end
        cycle(1'b1, 32'hBAD0_0000, 32'hBAD0_0001, 1'b1, 1'b1);
        check("flush_level", 32'(level), 32'd0);
        check("flush_hw",    32'(high_water), 32'd0);
        idle_check();
        cycle(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
        idle_check();
        check("post_flush_a", out_a, 32'h1234_5678);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges at level 2.
        cycle(1'b1, 32'h5555_0000, 32'h6666_0000, 1'b0, 1'b0);
        cycle(1'b1, 32'h5555_0001, 32'h6666_0001, 1'b0, 1'b0);
        in_valid = 1'b0; out_ready = 1'b0;
        check("pre_arst_level", 32'(level), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_hw",    32'(high_water), 32'd0);
        sb.delete();
        hw_model = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_check();
        cycle(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0);
        idle_check();
        check("after_arst_a", out_a, 32'h3F80_0000);
        check("after_arst_b", out_b, 32'h4000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpadd_operand_fifo.md
Name: fpadd_operand_fifo

Overview:
- Buffered operand front end for the floating-point adder IP.
- Accepts single-precision operand pairs (A, B) from the bus-side register interface over a valid/ready handshake.
- Holds them in a small circular FIFO and presents the head pair to the adder input stage, which pops it with its own ready.
- Decouples bus writes from adder back-pressure and reports occupancy and a high-water mark for software.

Parameters:
- DATA_W, 32, width of each operand (IEEE-754 single).
- DEPTH, 4, number of operand-pair entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy and high-water outputs.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- flush  in  1  synchronous clear of all entries, active-high.
- in_valid  in  1  upstream has an operand pair.
- in_ready  out  1  FIFO can accept a pair this cycle.
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- out_valid  out  1  head entry valid toward the adder.
- out_ready  in  1  adder accepts the head entry.
- out_a  out  DATA_W  head operand A.
- out_b  out  DATA_W  head operand B.
- level  out  CNT_W  current number of stored pairs, 0..DEPTH.
- high_water  out  CNT_W  maximum level reached since reset or flush.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr, rd_ptr, level and high_water go to 0.
  - out_valid=0, in_ready=1, out_a=0, out_b=0.
  - Storage contents are don't-care.
  - Release is sampled on the next rising edge.
- Push: occurs when in_valid && in_ready.
  - Writes {in_a, in_b} to mem[wr_ptr].
  - wr_ptr advances modulo DEPTH.
- Pop: occurs when out_valid && out_ready.
  - rd_ptr advances modulo DEPTH.
- in_ready = (level != DEPTH). It is combinational from registered level only and has no path from out_ready. When full there is no same-cycle pass-through: a pop while full does not permit a push that cycle.
- out_valid = (level != 0). out_a and out_b = mem[rd_ptr], registered storage read combinationally via the pointer.
- Latency: a pair pushed into an empty FIFO at edge N is visible with out_valid=1 after edge N. Minimum input-to-output latency is 1 cycle.
- Stability: while out_valid=1 and out_ready=0, out_a and out_b hold unchanged regardless of pushes.
- Level update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop (possible when 0<level<DEPTH).
  - At level=0, only a push can occur; at level=DEPTH, only a pop.
- high_water is updated to next-level whenever next-level exceeds it. It never decreases except on reset or flush.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full and empty are decided by level, never by pointer equality.
- flush=1:
  - Next edge sets wr_ptr, rd_ptr, level and high_water to 0.
  - flush has priority over push and pop in the same cycle; the pushed pair is discarded and the pop has no effect.
  - in_ready and out_valid follow the cleared level on the following cycle.
- Reset asserted mid-transfer: any in-flight handshake is abandoned and all state clears immediately. No partial entry survives.
- Inputs in_a and in_b are ignored when in_valid=0. Data values are opaque; no arithmetic is performed on operands.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release -> level=0, out_valid=0, in_ready=1, high_water=0.
- Single pair: push A=0x3F800000, B=0x40000000 with out_ready=0 -> next cycle out_valid=1, out_a=0x3F800000, out_b=0x40000000, level=1, outputs stable for 5 cycles.
- Fill (DEPTH=4):
  - Push 5 pairs back-to-back with out_ready=0 -> in_ready=0 after the 4th, 5th pair not accepted, level=4, high_water=4.
  - Then pop all 4 -> data in push order, level=0, high_water stays 4.
- Simultaneous traffic and wrap: stream 10 pairs with in_valid=1 and out_ready=1 continuously -> level stays at 1 after the first push, all 10 pairs emerge in order, pointers wrap twice with no loss.
- Flush priority: at level=3, assert flush together with a push and a pop -> next cycle level=0, out_valid=0, high_water=0, the pushed pair never appears.
- Asynchronous reset mid-operation: drop reset between edges at level=2 -> out_valid and level go to 0 immediately, without waiting for a clock edge; after release, a new push behaves as in the single-pair case.
